// File: rtl/image_fifo_writer.sv
`default_nettype none
// ============================================================================
// Module   : image_fifo_writer
// Purpose  : Write-side producer for the image dual-clock pixel FIFO. On a
//            start request it streams one full frame out of a synchronous
//            frame-buffer RAM in raster order (address 0 .. N-1, where
//            N = IMG_WIDTH*IMG_HEIGHT) and pushes every pixel into the FIFO
//            write port. It honours fifo_full without losing or duplicating
//            pixels.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   wr_clk      in   clock, all logic in this domain
//   reset       in   asynchronous, active-high reset
//   start       in   1-cycle frame request, ignored unless idle
//   busy        out  high from start acceptance until the done pulse
//   done        out  1-cycle pulse in the cycle the last pixel is written
//   mem_rd_en   out  RAM read strobe
//   mem_addr    out  RAM read address
//   mem_rdata   in   RAM data, valid exactly 1 cycle after mem_rd_en
//   fifo_wr_en  out  FIFO write enable
//   fifo_din    out  FIFO write data (skid-buffer head)
//   fifo_full   in   FIFO full flag
//   stall_cnt   out  cycles with a pixel waiting on fifo_full
//                    (only with IMAGE_FIFO_WRITER_STALL_CNT_EN defined)
// Configuration
//   `define IMAGE_FIFO_WRITER_STALL_CNT_EN  adds the saturating stall_cnt
// ============================================================================
module image_fifo_writer #(
    parameter  int DATA_WIDTH = 24,
    parameter  int IMG_WIDTH  = 720,
    parameter  int IMG_HEIGHT = 540,
    localparam int ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic                  wr_clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_din,
    input  logic                  fifo_full
`ifdef IMAGE_FIFO_WRITER_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    localparam int              CNT_WIDTH = ADDR_WIDTH + 1;
    localparam [CNT_WIDTH-1:0]  LAST_IDX  = CNT_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   rd_cnt;      // next address to read
    logic [CNT_WIDTH-1:0]   wr_cnt;      // pixels already written to the FIFO
    logic [DATA_WIDTH-1:0]  skid [0:1];
    logic                   rd_ptr;
    logic                   wr_ptr;
    logic [1:0]             occ;         // valid entries in the skid buffer
    logic                   inflight;    // read issued last cycle, data arriving now

    logic                   pop;
    logic [2:0]             level;

    // A pop needs a valid head and room downstream.
    assign pop        = (occ != 2'd0) && !fifo_full;
    assign fifo_wr_en = pop;
    assign fifo_din   = skid[rd_ptr];

    // Occupancy the buffer will have next cycle before any new read; a new
    // read is only allowed if its data is guaranteed a free slot.
    assign level      = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign mem_rd_en  = (state == ST_READ) && (level < 3'd2);
    assign mem_addr   = rd_cnt[ADDR_WIDTH-1:0];

    assign done       = (state == ST_DRAIN) && pop && (wr_cnt == LAST_IDX);

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            skid[0]  <= '0;
            skid[1]  <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            occ      <= 2'd0;
            inflight <= 1'b0;
        end else begin
            inflight <= mem_rd_en;

            // RAM return and pop are independent; both may happen together.
            if (inflight) begin
                skid[wr_ptr] <= mem_rdata;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                wr_cnt <= wr_cnt + 1'b1;
            end
            occ <= occ + {1'b0, inflight} - {1'b0, pop};

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_READ;
                        busy   <= 1'b1;
                        rd_cnt <= '0;
                        wr_cnt <= '0;
                    end
                end
                ST_READ: begin
                    if (mem_rd_en) begin
                        rd_cnt <= rd_cnt + 1'b1;
                        if (rd_cnt == LAST_IDX) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (done) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef IMAGE_FIFO_WRITER_STALL_CNT_EN
    // Counts cycles a buffered pixel is held back by fifo_full.
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= 32'd0;
        end else if ((state == ST_IDLE) && start) begin
            stall_cnt <= 32'd0;
        end else if ((occ != 2'd0) && fifo_full && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire
